// File: rtl/flex_cnt_pkg.sv
// Shared types and the single-step counting rule for the flexible counter bank.
package flex_cnt_pkg;

    // Widest channel the step function can handle; channels zero-extend into it
    // and take back only their own low bits.
    localparam int CNT_MAX_W = 32;

    typedef logic [CNT_MAX_W-1:0] cnt_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Result of one advance: the new count, whether it was a wrap event, and
    // whether saturation prevented the move.
    typedef struct packed {
        cnt_t next;
        logic wrap;
        logic blocked;
    } step_t;

    // One advance of a counter whose terminal value is rv.
    // A count above rv (rv lowered while running) is treated as sitting past the
    // limit: it always wraps straight back into range, even in saturate mode, so
    // the count never stays above rv for more than one advance.
    function automatic step_t next_cnt(
        input cnt_t cnt,
        input cnt_t rv,
        input dir_e dir,
        input logic sat
    );
        step_t r;
        r.next    = cnt;
        r.wrap    = 1'b0;
        r.blocked = 1'b0;
        if (cnt > rv) begin
            r.next = (dir == DIR_UP) ? '0 : rv;
            r.wrap = 1'b1;
        end else if (dir == DIR_UP) begin
            if (cnt != rv) begin
                r.next = cnt + cnt_t'(1);
            end else if (sat) begin
                r.blocked = 1'b1;
            end else begin
                r.next = '0;
                r.wrap = 1'b1;
            end
        end else begin
            if (cnt != '0) begin
                r.next = cnt - cnt_t'(1);
            end else if (sat) begin
                r.blocked = 1'b1;
            end else begin
                r.next = rv;
                r.wrap = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: count register, next-state selection and its three
// registered flags. wrap_ev is the combinational wrap event of this cycle, used
// by the next channel as its cascade carry.
module flex_counter_ch
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    adv,
    input  logic                    dir_up,
    input  logic                    sat_mode,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    sat_flag,
    output logic                    wrap_ev
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic                    rollover_q;
    logic                    rollover_d;
    logic                    wrap_q;
    logic                    wrap_d;
    logic                    sat_q;
    logic                    sat_d;
    step_t                   adv_res;

    // Outcome of an advance from the current count, evaluated every cycle.
    always_comb begin
        adv_res = next_cnt(cnt_t'(count_q), cnt_t'(rollover_val), dir_e'(dir_up), sat_mode);
    end

    // The step function works at full package width; only the low bits matter here.
    generate
        if (NUM_CNT_BITS < CNT_MAX_W) begin : g_hi_sink
            logic unused_hi;
            assign unused_hi = ^adv_res.next[CNT_MAX_W-1:NUM_CNT_BITS];
        end
    endgenerate

    // Next count with clear > load > advance > hold; clear and load never wrap.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val < rollover_val) ? load_val : rollover_val;
        end else if (adv) begin
            count_d = adv_res.next[NUM_CNT_BITS-1:0];
            wrap_d  = adv_res.wrap;
            sat_d   = adv_res.blocked;
        end
        rollover_d = (count_d == rollover_val);
    end

    assign wrap_ev = wrap_d;

    // Count and flags register together so the flags line up with count_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = rollover_q;
    assign wrap_pulse    = wrap_q;
    assign sat_flag      = sat_q;

endmodule

// File: rtl/multi_flex_counter.sv
// Bank of NUM_CH flexible counters. With CASCADE set, each channel above 0
// advances only when the channel below wraps in the same cycle, so the carry
// ripples through the whole bank combinationally.
module multi_flex_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2,
    parameter int CASCADE      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              dir_up,
    input  logic [NUM_CH-1:0]              sat_mode,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              wrap_pulse,
    output logic [NUM_CH-1:0]              sat_flag,
    output logic                           any_wrap
);

    logic [NUM_CH-1:0] wrap_ev_all;
    logic              any_wrap_q;
    logic              any_wrap_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic ch_adv;
            logic ch_wrap;

            // Carry is taken from the previous block's own wire rather than a
            // shared vector so the ripple chain has no bit-to-bit self loop.
            if (CASCADE != 0 && gi > 0) begin : g_casc
                assign ch_adv = count_enable[gi] & g_ch[gi-1].ch_wrap;
            end else begin : g_free
                assign ch_adv = count_enable[gi];
            end

            flex_counter_ch #(
                .NUM_CNT_BITS (NUM_CNT_BITS)
            ) u_ch (
                .clk           (clk),
                .rst           (rst),
                .clear         (clear[gi]),
                .load          (load[gi]),
                .adv           (ch_adv),
                .dir_up        (dir_up[gi]),
                .sat_mode      (sat_mode[gi]),
                .load_val      (load_val[gi*NUM_CNT_BITS +: NUM_CNT_BITS]),
                .rollover_val  (rollover_val[gi*NUM_CNT_BITS +: NUM_CNT_BITS]),
                .count_out     (count_out[gi*NUM_CNT_BITS +: NUM_CNT_BITS]),
                .rollover_flag (rollover_flag[gi]),
                .wrap_pulse    (wrap_pulse[gi]),
                .sat_flag      (sat_flag[gi]),
                .wrap_ev       (ch_wrap)
            );

            assign wrap_ev_all[gi] = ch_wrap;
        end
    endgenerate

    // OR of this cycle's wrap events; registered so it matches wrap_pulse timing.
    always_comb begin
        any_wrap_d = |wrap_ev_all;
    end

    // Summary wrap register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_wrap_q <= 1'b0;
        end else begin
            any_wrap_q <= any_wrap_d;
        end
    end

    assign any_wrap = any_wrap_q;

endmodule

// File: tb/tb_multi_flex_counter.sv
// Bench for multi_flex_counter: a free-running bank and a cascaded bank share
// the same stimulus and are both compared against an arithmetic model.
module tb_multi_flex_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] clear, load, count_enable, dir_up, sat_mode;
    logic [7:0] load_val, rollover_val;

    logic [7:0] co_q [2];
    logic [1:0] rf_q [2];
    logic [1:0] wp_q [2];
    logic [1:0] sf_q [2];
    logic       aw_q [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, [config][channel]; config 0 = free running, 1 = cascaded.
    int m_cnt [2][2];
    bit m_rf  [2][2];
    bit m_wp  [2][2];
    bit m_sf  [2][2];
    bit m_any [2];
    int n_cnt [2][2];
    bit n_rf  [2][2];
    bit n_wp  [2][2];
    bit n_sf  [2][2];
    bit n_any [2];

    always #5 clk = ~clk;

    multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .count_enable(count_enable),
        .dir_up(dir_up), .sat_mode(sat_mode), .load_val(load_val), .rollover_val(rollover_val),
        .count_out(co_q[0]), .rollover_flag(rf_q[0]), .wrap_pulse(wp_q[0]),
        .sat_flag(sf_q[0]), .any_wrap(aw_q[0])
    );

    multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .count_enable(count_enable),
        .dir_up(dir_up), .sat_mode(sat_mode), .load_val(load_val), .rollover_val(rollover_val),
        .count_out(co_q[1]), .rollover_flag(rf_q[1]), .wrap_pulse(wp_q[1]),
        .sat_flag(sf_q[1]), .any_wrap(aw_q[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_any[c] = 0;
            for (int h = 0; h < 2; h++) begin
                m_cnt[c][h] = 0; m_rf[c][h] = 0; m_wp[c][h] = 0; m_sf[c][h] = 0;
            end
        end
    endtask

    // Next state from the current inputs. Counting within range is modular over
    // rv+1 values; a count above rv snaps back into range.
    task automatic model_eval();
        for (int c = 0; c < 2; c++) begin
            bit carry = 0;
            n_any[c] = 0;
            for (int h = 0; h < 2; h++) begin
                int cur = m_cnt[c][h];
                int rv  = int'(rollover_val[h*4 +: 4]);
                int lv  = int'(load_val[h*4 +: 4]);
                bit adv = count_enable[h] && (c == 0 || h == 0 || carry);
                int nxt = cur;
                bit w = 0;
                bit b = 0;
                if (clear[h]) nxt = 0;
                else if (load[h]) nxt = (lv < rv) ? lv : rv;
                else if (adv) begin
                    if (cur > rv) begin
                        nxt = dir_up[h] ? 0 : rv;
                        w = 1;
                    end else begin
                        bit at_edge = dir_up[h] ? (cur == rv) : (cur == 0);
                        if (at_edge && sat_mode[h]) b = 1;
                        else begin
                            nxt = dir_up[h] ? (cur + 1) % (rv + 1) : (cur + rv) % (rv + 1);
                            w = at_edge;
                        end
                    end
                end
                carry = w;
                n_cnt[c][h] = nxt;
                n_rf[c][h] = (nxt == rv);
                n_wp[c][h] = w;
                n_sf[c][h] = b;
                n_any[c] = n_any[c] | w;
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int c = 0; c < 2; c++) begin
            logic [7:0] ec;
            logic [1:0] erf, ewp, esf;
            for (int h = 0; h < 2; h++) begin
                ec[h*4 +: 4] = 4'(m_cnt[c][h]);
                erf[h] = m_rf[c][h];
                ewp[h] = m_wp[c][h];
                esf[h] = m_sf[c][h];
            end
            check($sformatf("%s/cfg%0d/count_out", tag, c), 32'(co_q[c]), 32'(ec));
            check($sformatf("%s/cfg%0d/rollover_flag", tag, c), 32'(rf_q[c]), 32'(erf));
            check($sformatf("%s/cfg%0d/wrap_pulse", tag, c), 32'(wp_q[c]), 32'(ewp));
            check($sformatf("%s/cfg%0d/sat_flag", tag, c), 32'(sf_q[c]), 32'(esf));
            check($sformatf("%s/cfg%0d/any_wrap", tag, c), 32'(aw_q[c]), 32'(m_any[c]));
        end
    endtask

    // One clock: evaluate the model on the applied inputs, clock, compare.
    task automatic step(input string tag);
        model_eval();
        @(posedge clk);
        #1;
        m_cnt = n_cnt; m_rf = n_rf; m_wp = n_wp; m_sf = n_sf; m_any = n_any;
        check_model(tag);
        $display("[TB] %s cnt=%h/%h rf=%b/%b wp=%b/%b sf=%b/%b", tag,
                 co_q[0], co_q[1], rf_q[0], rf_q[1], wp_q[0], wp_q[1], sf_q[0], sf_q[1]);
    endtask

    typedef struct {
        bit       clr, ld, en, up, sat;
        bit [3:0] lv, rv;
        bit [3:0] e_cnt;
        bit       e_rf, e_wp, e_sf;
    } vec_t;

    vec_t vecs [19];

    initial begin
        rst = 1'b1;
        clear = '0; load = '0; count_enable = '0; dir_up = '0; sat_mode = '0;
        load_val = '0; rollover_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        // Count ch0 up to 7, then reset asynchronously between clock edges.
        rollover_val = 8'h3F;
        count_enable = 2'b01;
        dir_up = 2'b11;
        for (int k = 0; k < 7; k++) step("pre_rst");
        check("pre_rst/ch0", 32'(co_q[0][3:0]), 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("async_rst/cfg%0d/outs", c),
                  {co_q[c], rf_q[c], wp_q[c], sf_q[c], aw_q[c]}, 32'd0);
        end
        #1;
        rst = 1'b0;
        step("post_rst");
        check("post_rst/ch0", 32'(co_q[0][3:0]), 32'd1);

        // Directed table for ch0; ch1 idle with rv 3.
        //          clr ld en up sat lv   rv     cnt  rf wp sf
        vecs[0]  = '{1, 0, 0, 1, 0, 0,  5,     0,   0, 0, 0};
        vecs[1]  = '{0, 0, 1, 1, 0, 0,  5,     1,   0, 0, 0};
        vecs[2]  = '{0, 0, 1, 1, 0, 0,  5,     2,   0, 0, 0};
        vecs[3]  = '{0, 0, 1, 1, 0, 0,  5,     3,   0, 0, 0};
        vecs[4]  = '{0, 0, 1, 1, 0, 0,  5,     4,   0, 0, 0};
        vecs[5]  = '{0, 0, 1, 1, 0, 0,  5,     5,   1, 0, 0};
        vecs[6]  = '{0, 0, 1, 1, 0, 0,  5,     0,   0, 1, 0};
        vecs[7]  = '{0, 0, 1, 0, 0, 0,  9,     9,   1, 1, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 0,  9,     0,   0, 0, 0};
        vecs[9]  = '{0, 0, 1, 0, 1, 0,  9,     0,   0, 0, 1};
        vecs[10] = '{0, 0, 1, 0, 1, 0,  9,     0,   0, 0, 1};
        vecs[11] = '{1, 1, 1, 1, 0, 12, 10,    0,   0, 0, 0};
        vecs[12] = '{0, 1, 1, 1, 0, 12, 10,    10,  1, 0, 0};
        vecs[13] = '{0, 1, 0, 1, 0, 8,  15,    8,   0, 0, 0};
        vecs[14] = '{0, 0, 1, 1, 0, 0,  4,     0,   0, 1, 0};
        vecs[15] = '{0, 0, 1, 1, 0, 0,  0,     0,   1, 1, 0};
        vecs[16] = '{0, 0, 1, 1, 0, 0,  0,     0,   1, 1, 0};
        vecs[17] = '{0, 0, 1, 1, 1, 0,  0,     0,   1, 0, 1};
        vecs[18] = '{0, 0, 0, 1, 0, 0,  0,     0,   1, 0, 0};
        for (int v = 0; v < 19; v++) begin
            clear = {1'b0, vecs[v].clr};
            load = {1'b0, vecs[v].ld};
            count_enable = {1'b0, vecs[v].en};
            dir_up = {1'b1, vecs[v].up};
            sat_mode = {1'b0, vecs[v].sat};
            load_val = {4'd0, vecs[v].lv};
            rollover_val = {4'd3, vecs[v].rv};
            step($sformatf("vec%0d", v));
            check($sformatf("vec%0d/cnt", v), 32'(co_q[0][3:0]), 32'(vecs[v].e_cnt));
            check($sformatf("vec%0d/rf", v), 32'(rf_q[0][0]), 32'(vecs[v].e_rf));
            check($sformatf("vec%0d/wp", v), 32'(wp_q[0][0]), 32'(vecs[v].e_wp));
            check($sformatf("vec%0d/sf", v), 32'(sf_q[0][0]), 32'(vecs[v].e_sf));
            check($sformatf("vec%0d/any", v), 32'(aw_q[0]), 32'(vecs[v].e_wp));
        end

        // Cascade: both rv 3, counting up from zero.
        clear = 2'b11; load = '0; count_enable = '0; sat_mode = '0;
        rollover_val = 8'h33; dir_up = 2'b11;
        step("casc_clr");
        clear = '0; count_enable = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            step($sformatf("casc%0d", k));
            if (k == 4) check("casc4/ch1", 32'(co_q[1][7:4]), 32'd1);
            if (k == 15) check("casc15/cnt", 32'(co_q[1]), 32'h33);
            if (k == 16) begin
                check("casc16/cnt", 32'(co_q[1]), 32'h00);
                check("casc16/wp", 32'(wp_q[1]), 32'h3);
                check("casc16/any", 32'(aw_q[1]), 32'h1);
            end
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            for (int h = 0; h < 2; h++) begin
                clear[h] = ($urandom_range(0, 15) == 0);
                load[h] = ($urandom_range(0, 9) == 0);
                count_enable[h] = ($urandom_range(0, 3) != 0);
                dir_up[h] = 1'($urandom_range(0, 1));
                sat_mode[h] = ($urandom_range(0, 3) == 0);
                load_val[h*4 +: 4] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0)
                    rollover_val[h*4 +: 4] = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            step($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
